// File: rtl/proc_ctrl.sv
// Multi-cycle control unit: fetches 16-bit instructions, sequences datapath strobes, owns pc/zflag/err.
// Optional single-step mode under PROC_CTRL_STEP_EN (adds a `step` input, one instruction per rising edge).
module proc_ctrl #(
    parameter logic [2:0] PASS_FN  = 3'd0,
    parameter int         NUM_REGS = 5
) (
    input  logic        clk,
    input  logic        rst,
`ifdef PROC_CTRL_STEP_EN
    input  logic        step,
`endif
    output logic        instr_req,
    output logic [7:0]  pc,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    input  logic        alu_zero,
    output logic        en_imm,
    output logic        en_reg,
    output logic        en_alu,
    output logic        en_rf,
    output logic        r_wf,
    output logic        sel_mux,
    output logic [2:0]  sel_alu,
    output logic [3:0]  sel_rf,
    output logic [7:0]  imm,
    output logic        zflag,
    output logic        halted,
    output logic        err
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_RDA    = 3'd2,
        S_LDA    = 3'd3,
        S_EXE    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [3:0] OP_LDI  = 4'd1;
    localparam logic [3:0] OP_ALUR = 4'd2;
    localparam logic [3:0] OP_ALUI = 4'd3;
    localparam logic [3:0] OP_JZ   = 4'd4;
    localparam logic [3:0] OP_JMP  = 4'd5;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam logic [4:0] NREG = 5'(NUM_REGS);

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        zflag_q, zflag_d;
    logic        err_q, err_d;

    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [2:0]  fn;
    logic        reg_op;
    logic        illegal;
    logic        fetch_go;
    logic        handshake;

    assign op  = ir_q[15:12];
    assign rd  = ir_q[11:8];
    assign rs  = ir_q[7:4];
    assign fn  = ir_q[2:0];
    assign imm = ir_q[7:0];

    assign reg_op  = (op == OP_LDI) || (op == OP_ALUR) || (op == OP_ALUI);
    // Only ALUR reads a second register, so rs is checked for it alone.
    assign illegal = reg_op && (({1'b0, rd} >= NREG) ||
                                ((op == OP_ALUR) && ({1'b0, rs} >= NREG)));

    assign handshake = (state_q == S_FETCH) && fetch_go && instr_valid;

`ifdef PROC_CTRL_STEP_EN
    logic step_q, step_d;
    logic armed_q, armed_d;

    // A rising edge arms one fetch; the handshake consumes it.
    always_comb begin
        step_d  = step;
        armed_d = (armed_q && !handshake) || (step && !step_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            step_q  <= step_d;
            armed_q <= armed_d;
        end
    end

    assign fetch_go = armed_q;
`else
    assign fetch_go = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        zflag_d   = zflag_q;
        err_d     = err_q;
        instr_req = 1'b0;
        en_imm    = 1'b0;
        en_reg    = 1'b0;
        en_alu    = 1'b0;
        en_rf     = 1'b0;
        r_wf      = 1'b0;
        sel_mux   = 1'b0;
        sel_alu   = 3'd0;
        sel_rf    = 4'd0;
        halted    = 1'b0;

        case (state_q)
            S_FETCH: begin
                instr_req = fetch_go;
                if (handshake) begin
                    ir_d    = instr;
                    pc_d    = pc_q + 8'd1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                en_imm = 1'b1;
                if (illegal) begin
                    err_d   = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    case (op)
                        OP_LDI:           state_d = S_EXE;
                        OP_ALUR, OP_ALUI: state_d = S_RDA;
                        OP_JZ: begin
                            if (zflag_q) begin
                                pc_d = imm;
                            end
                            state_d = S_FETCH;
                        end
                        OP_JMP: begin
                            pc_d    = imm;
                            state_d = S_FETCH;
                        end
                        OP_HALT:          state_d = S_HALT;
                        default:          state_d = S_FETCH;
                    endcase
                end
            end
            S_RDA: begin
                en_rf   = 1'b1;
                sel_rf  = rd;
                state_d = S_LDA;
            end
            S_LDA: begin
                // op2 latches rf[rd] while rs is requested for the ALUR op1 path.
                en_reg = 1'b1;
                if (op == OP_ALUR) begin
                    en_rf  = 1'b1;
                    sel_rf = rs;
                end
                state_d = S_EXE;
            end
            S_EXE: begin
                en_alu  = 1'b1;
                sel_mux = (op != OP_ALUR);
                sel_alu = (op == OP_LDI) ? PASS_FN : fn;
                state_d = S_WB;
            end
            S_WB: begin
                en_rf   = 1'b1;
                r_wf    = 1'b1;
                sel_rf  = rd;
                zflag_d = alu_zero;
                state_d = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= 8'd0;
            ir_q    <= 16'd0;
            zflag_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            zflag_q <= zflag_d;
            err_q   <= err_d;
        end
    end

    assign pc    = pc_q;
    assign zflag = zflag_q;
    assign err   = err_q;

endmodule

// File: doc/proc_ctrl.md
# proc_ctrl

Multi-cycle control unit for the simple processor datapath. It fetches 16-bit instructions over a valid/request handshake and decodes them. It then drives the datapath strobes (`en_imm`, `en_reg`, `en_alu`, `en_rf`, `r_wf`) and selects (`sel_mux`, `sel_alu`, `sel_rf`) in a fixed per-instruction state sequence. It also keeps the program counter and a zero flag sampled from `alu_zero` for conditional jumps.

## Interface
Parameters:
- `PASS_FN`, default 3'd0: `sel_alu` code for which the ALU output equals in1 (op1). Used by LDI.
- `NUM_REGS`, default 5: number of valid register-file entries. A register index ≥ `NUM_REGS` is illegal.

Ports:
- `clk`  in  1  single clock; all logic updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr_req`  out  1  fetch request; held high in FETCH.
- `pc`  out  8  instruction address; stable while `instr_req` is high.
- `instr`  in  16  instruction word; sampled when `instr_valid` and `instr_req` are both high.
- `instr_valid`  in  1  instruction word is valid.
- `alu_zero`  in  1  zero flag from the datapath ALU.
- `en_imm`, `en_reg`, `en_alu`, `en_rf`, `r_wf`  out  1 each  datapath strobes; `r_wf=1` means write, 0 means read.
- `sel_mux`  out  1  op1 source: 1 = immediate register, 0 = register-file output.
- `sel_alu`  out  3  ALU function.
- `sel_rf`  out  4  register index.
- `imm`  out  8  immediate value, which is `instr[7:0]` of the current instruction.
- `zflag`  out  1  zero flag captured at writeback.
- `halted`  out  1  HALT was executed.
- `err`  out  1  sticky flag set by an illegal register index.

## Operation
Instruction format: `[15:12]` op, `[11:8]` rd, `[7:0]` imm. For register-source forms, `[7:4]` is rs and `[2:0]` is fn.

Opcodes:
- 0 NOP.
- 1 LDI: rd ← imm.
- 2 ALUR: rd ← rd fn rs.
- 3 ALUI: rd ← rd fn imm.
- 4 JZ: if `zflag`, pc ← imm.
- 5 JMP: pc ← imm.
- 15 HALT.
- All other opcodes behave as NOP.

States: FETCH, DECODE, RDA, LDA, EXE, WB, HALT.

- **FETCH**
  - Drive `instr_req=1`.
  - On the handshake: IR ← `instr`, pc ← pc+1 (wraps 8'hFF → 8'h00), go to DECODE.
- **DECODE**
  - Assert `en_imm=1` for every opcode.
  - An illegal rd (or an illegal rs for ALUR) on opcodes 1–3: set `err`, return to FETCH, no datapath write.
  - LDI → EXE.
  - ALUR, ALUI → RDA.
  - JZ: if `zflag`, pc ← imm; then FETCH.
  - JMP: pc ← imm; then FETCH.
  - HALT → HALT.
  - NOP or undefined opcode → FETCH.
- **RDA**
  - Drive `en_rf=1`, `r_wf=0`, `sel_rf=rd`. The register file returns data on the next cycle.
  - → LDA.
- **LDA**
  - Drive `sel_mux=0`, `en_reg=1`, which latches op2 ← rf[rd].
  - ALUR only: also drive `en_rf=1`, `r_wf=0`, `sel_rf=rs`.
  - → EXE.
- **EXE**
  - Drive `en_alu=1`.
  - `sel_mux`: 0 for ALUR, 1 for ALUI and LDI.
  - `sel_alu`: `PASS_FN` for LDI, otherwise fn.
  - → WB.
- **WB**
  - Drive `en_rf=1`, `r_wf=1`, `sel_rf=rd`. The register file writes the registered `alu_out`.
  - zflag ← `alu_zero`.
  - → FETCH.
- **HALT**
  - `halted=1`. Stays in HALT until `rst`.

Default outputs: any strobe or select not named in a state is 0 in that state; `imm` always equals IR[7:0].

## Timing
- Reset (synchronous, takes effect at the next edge): state FETCH, pc=0, IR=0, zflag=0, err=0, halted=0. All strobes are 0 and `sel_*`=0. `instr_req` is 1 from the first cycle after reset.
- With zero-wait fetch, cycles per instruction are:
  - ALUR, ALUI: 6.
  - LDI: 4.
  - NOP, JZ, JMP, illegal: 2.
- FETCH waits indefinitely while `instr_valid=0`; pc holds during the wait.
- `instr_valid` outside FETCH is ignored.
- Exactly one strobe-active state per datapath action; no strobe is ever asserted for two consecutive cycles by a single state.
- `rst` during any state, including WB, takes precedence. No write strobe is issued in the cycle after the reset edge.
- JZ uses the `zflag` captured by the last WB, not the live `alu_zero`.

## Configuration
- `PROC_CTRL_STEP_EN`
  - **Defined:** adds input `step` (1 bit). FETCH asserts `instr_req` only after a `step` rising edge has been detected, and one pulse executes one instruction. `step` is edge-detected, so holding it high does not auto-repeat.
  - **Undefined:** no `step` port; FETCH requests immediately.

## Test plan
- Reset, then LDI r1,5 → DECODE `en_imm=1`; EXE `sel_mux=1`, `sel_alu=PASS_FN`; WB `en_rf=1`, `r_wf=1`, `sel_rf=1`; 4 cycles total; pc=1.
- LDI r1,5; LDI r2,5; ALUR r1,r2 with a subtract fn → RDA `sel_rf=1`; LDA `en_reg=1`, `sel_rf=2`; EXE `sel_mux=0`; WB writes r1; `zflag=1`. A following JZ 8'h20 → pc=0x20.
- ALUI r3 with zflag=0, then JZ 8'h40 → not taken, pc increments; JMP 8'h00 → pc=0.
- LDI rd=7 (NUM_REGS=5) → `err=1`, no `en_rf` write, 2 cycles, execution continues.
- `instr_valid` held low for 3 cycles in FETCH → `instr_req` stays 1 and pc is stable. Assert `rst` in EXE → next cycle all strobes 0 and pc=0.
- HALT → `halted=1` permanently, `instr_req=0`. With `PROC_CTRL_STEP_EN` defined, 2 `step` pulses → exactly 2 fetches.
